// File: rtl/lab5_g7_capture.sv
// Input-capture unit: measures period and high width of cap_in
// in prescaled ticks, reported through a valid/ack handshake.
module lab5_g7_capture #(
    parameter int CNT_W       = 16,
    parameter int PSC_W       = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [PSC_W-1:0] psc,
    input  logic             cap_in,
    input  logic             ack,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] width,
    output logic             valid,
    output logic             ovf,
    output logic             ovr
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        HIGH,
        LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t state;
    state_t state_nx;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s_last;
    logic                   s_prev;
    logic                   rise;
    logic                   fall;

    logic [PSC_W-1:0] pc;
    logic             tick;

    logic [CNT_W-1:0] tc;
    logic [CNT_W-1:0] wtmp;
    logic [CNT_W-1:0] cval;
    logic             tc_max;

    logic res_load;
    logic wtmp_load;
    logic ovf_set;
    logic ack_eff;

    assign s_last = sync[SYNC_STAGES-1];
    assign rise   = s_last & ~s_prev;
    assign fall   = ~s_last & s_prev;

    // >= rather than == so a psc lowered below pc still wraps promptly
    assign tick   = en & (pc >= psc);

    assign tc_max = (tc == CNT_MAX);
    assign cval   = tc_max ? CNT_MAX : (tick ? tc + CNT_ONE : tc);

    assign ack_eff = ack & valid;

    // Synchroniser chain plus previous-sample flop for edge detect
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync   <= '0;
            s_prev <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], cap_in};
            s_prev <= s_last;
        end
    end

    // Free-running prescaler, held at zero while disabled
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= '0;
        end else if (!en) begin
            pc <= '0;
        end else if (tick) begin
            pc <= '0;
        end else begin
            pc <= pc + PSC_W'(1);
        end
    end

    // Tick counter: cleared on every rise, saturates at all-ones
    always_ff @(posedge clk) begin
        if (!reset) begin
            tc <= '0;
        end else if (!en) begin
            tc <= '0;
        end else if (rise) begin
            tc <= '0;
        end else if (tick && !tc_max) begin
            tc <= tc + CNT_ONE;
        end
    end

    // Width held here until the closing rise completes the period
    always_ff @(posedge clk) begin
        if (!reset) begin
            wtmp <= '0;
        end else if (!en) begin
            wtmp <= '0;
        end else if (wtmp_load) begin
            wtmp <= cval;
        end
    end

    // Measurement state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and per-cycle strobes
    always_comb begin
        state_nx  = state;
        res_load  = 1'b0;
        wtmp_load = 1'b0;
        ovf_set   = 1'b0;
        if (!en) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = ARMED;
                end
                ARMED: begin
                    if (rise) begin
                        state_nx = HIGH;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        wtmp_load = 1'b1;
                        state_nx  = LOW;
                    end else if (tc_max && tick) begin
                        ovf_set  = 1'b1;
                        state_nx = ARMED;
                    end
                end
                LOW: begin
                    if (rise) begin
                        res_load = 1'b1;
                        state_nx = HIGH;
                    end else if (tc_max && tick) begin
                        ovf_set  = 1'b1;
                        state_nx = ARMED;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // Result registers and sticky flags; set events win over ack clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            period <= '0;
            width  <= '0;
            valid  <= 1'b0;
            ovf    <= 1'b0;
            ovr    <= 1'b0;
        end else begin
            if (ack_eff) begin
                valid <= 1'b0;
                ovf   <= 1'b0;
                ovr   <= 1'b0;
            end
            if (res_load) begin
                period <= cval;
                width  <= wtmp;
                valid  <= 1'b1;
                if (valid && !ack) begin
                    ovr <= 1'b1;
                end
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lab5_g7_capture.sv
// Testbench for lab5_g7_capture: directed waveform table,
// multi-cycle corner sequences and a randomized model check.
module tb_lab5_g7_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [4:0]  psc = '0;
    logic        cap_in = 1'b0;
    logic        ack = 1'b0;
    logic [15:0] period;
    logic [15:0] width;
    logic        valid;
    logic        ovf;
    logic        ovr;

    int checks = 0;
    int errors = 0;

    lab5_g7_capture dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .psc    (psc),
        .cap_in (cap_in),
        .ack    (ack),
        .period (period),
        .width  (width),
        .valid  (valid),
        .ovf    (ovf),
        .ovr    (ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int psc;
        int hi;
        int lo;
        int ep;
        int ew;
    } vec_t;

    vec_t vt[6];

    // reference model state
    bit model_on = 0;
    bit m_hist[$];
    int m_n;
    bit m_armed;
    bit m_open;
    bit m_fall_seen;
    int m_cnt;
    int m_wid;
    bit m_valid;
    bit m_ovf;
    bit m_ovr;
    int m_period;
    int m_width;

    task automatic chk(input string name, input logic [39:0] got,
                       input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int sat(input int x);
        return (x > 65535) ? 65535 : x;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        repeat (4) m_hist.push_front(1'b0);
        m_n = 0;
        m_armed = 0;
        m_open = 0;
        m_fall_seen = 0;
        m_cnt = 0;
        m_wid = 0;
        m_valid = 0;
        m_ovf = 0;
        m_ovr = 0;
        m_period = 0;
        m_width = 0;
    endtask

    // One clock edge of spec-level behaviour, using current inputs
    task automatic model_step();
        bit r, f, tk, v_old, closing, res;
        int p_new;
        res = 0;
        p_new = 0;
        m_hist.push_front(cap_in);
        while (m_hist.size() > 4) void'(m_hist.pop_back());
        r = m_hist[2] && !m_hist[3];
        f = !m_hist[2] && m_hist[3];
        tk = en && ((m_n % (int'(psc) + 1)) == int'(psc));
        m_n = en ? m_n + 1 : 0;
        v_old = m_valid;
        if (ack && v_old) begin
            m_valid = 0;
            m_ovf = 0;
            m_ovr = 0;
        end
        if (!en) begin
            m_armed = 0;
            m_open = 0;
            m_fall_seen = 0;
            m_cnt = 0;
        end else if (!m_armed) begin
            m_armed = 1;
        end else begin
            closing = m_open && (m_fall_seen ? r : f);
            if (m_open && !closing && tk && m_cnt >= 65535) begin
                m_ovf = 1;
                m_open = 0;
                m_fall_seen = 0;
            end else if (r) begin
                if (m_open && m_fall_seen) begin
                    res = 1;
                    p_new = sat(m_cnt + int'(tk));
                end
                m_open = 1;
                m_fall_seen = 0;
                m_cnt = 0;
            end else begin
                if (f && m_open && !m_fall_seen) begin
                    m_wid = sat(m_cnt + int'(tk));
                    m_fall_seen = 1;
                end
                m_cnt += int'(tk);
            end
        end
        if (res) begin
            if (v_old && !ack) m_ovr = 1;
            m_valid = 1;
            m_period = p_new;
            m_width = m_wid;
        end
    endtask

    task automatic cyc();
        if (model_on) model_step();
        @(posedge clk);
        #1;
        if (model_on) begin
            chk("model", {5'd0, valid, ovf, ovr, period, width},
                {5'd0, m_valid, m_ovf, m_ovr,
                 m_period[15:0], m_width[15:0]});
        end
    endtask

    task automatic reset_dut();
        reset = 0;
        en = 0;
        ack = 0;
        cap_in = 0;
        cyc();
        cyc();
        reset = 1;
    endtask

    task automatic pulse(input int hi, input int lo);
        cap_in = 1;
        repeat (hi) cyc();
        cap_in = 0;
        repeat (lo) cyc();
    endtask

    task automatic wait_valid(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (valid === 1'b1) break;
        end
        chk(name, valid, 1);
    endtask

    task automatic do_ack();
        ack = 1;
        cyc();
        ack = 0;
    endtask

    initial begin
        int run;
        int off;

        vt[0] = '{psc: 0, hi: 8,  lo: 12, ep: 20, ew: 8};
        vt[1] = '{psc: 3, hi: 32, lo: 48, ep: 20, ew: 8};
        vt[2] = '{psc: 0, hi: 1,  lo: 1,  ep: 2,  ew: 1};
        vt[3] = '{psc: 1, hi: 6,  lo: 10, ep: 8,  ew: 3};
        vt[4] = '{psc: 7, hi: 40, lo: 24, ep: 8,  ew: 5};
        vt[5] = '{psc: 2, hi: 3,  lo: 3,  ep: 2,  ew: 1};

        // reset state
        reset_dut();
        chk("rst_period", period, 0);
        chk("rst_width", width, 0);
        chk("rst_valid", valid, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_ovr", ovr, 0);

        // table of waveforms
        for (int i = 0; i < 6; i++) begin
            reset_dut();
            psc = vt[i].psc[4:0];
            en = 1;
            repeat (4) cyc();
            pulse(vt[i].hi, vt[i].lo);
            chk("tbl_first_rise_silent", valid, 0);
            cap_in = 1;
            wait_valid("tbl_valid", 8);
            chk("tbl_period", period, vt[i].ep);
            chk("tbl_width", width, vt[i].ew);
            chk("tbl_ovr", ovr, 0);
            do_ack();
            chk("tbl_ack_clears", valid, 0);
        end

        // overwrite of un-acked results
        reset_dut();
        psc = 0;
        en = 1;
        repeat (4) cyc();
        pulse(8, 12);
        pulse(8, 12);
        chk("ovr_first_valid", valid, 1);
        chk("ovr_first_clear", ovr, 0);
        pulse(6, 10);
        cap_in = 1;
        repeat (4) cyc();
        chk("ovr_valid", valid, 1);
        chk("ovr_set", ovr, 1);
        chk("ovr_period", period, 16);
        chk("ovr_width", width, 6);
        do_ack();
        chk("ovr_ack_valid", valid, 0);
        chk("ovr_ack_ovr", ovr, 0);
        cap_in = 0;

        // counter saturation
        reset_dut();
        psc = 0;
        en = 1;
        repeat (4) cyc();
        cap_in = 1;
        repeat (65000) cyc();
        chk("ovf_not_yet", ovf, 0);
        repeat (5000) cyc();
        chk("ovf_set", ovf, 1);
        chk("ovf_no_valid", valid, 0);
        cap_in = 0;
        repeat (10) cyc();
        pulse(8, 12);
        cap_in = 1;
        wait_valid("ovf_next_valid", 8);
        chk("ovf_next_period", period, 20);
        chk("ovf_next_width", width, 8);
        chk("ovf_sticky", ovf, 1);
        do_ack();
        chk("ovf_ack_clears", ovf, 0);
        cap_in = 0;

        // enable dropped mid-LOW
        reset_dut();
        psc = 0;
        en = 1;
        repeat (4) cyc();
        pulse(8, 12);
        pulse(8, 2);
        do_ack();
        en = 0;
        repeat (5) cyc();
        en = 1;
        repeat (4) cyc();
        chk("en_no_valid", valid, 0);
        pulse(10, 10);
        chk("en_first_rise_silent", valid, 0);
        cap_in = 1;
        wait_valid("en_valid", 8);
        chk("en_period", period, 20);
        chk("en_width", width, 10);

        // reset while a result is pending
        do_ack();
        cap_in = 0;
        repeat (4) cyc();
        pulse(8, 12);
        cap_in = 1;
        wait_valid("rstmid_valid", 8);
        reset = 0;
        cyc();
        reset = 1;
        chk("rstmid_period", period, 0);
        chk("rstmid_width", width, 0);
        chk("rstmid_valid", valid, 0);

        // ack coinciding with a new result
        cap_in = 0;
        repeat (4) cyc();
        pulse(8, 12);
        pulse(6, 9);
        chk("coin_a_valid", valid, 1);
        chk("coin_a_period", period, 20);
        cap_in = 1;
        cyc();
        cyc();
        ack = 1;
        cyc();
        ack = 0;
        chk("coin_valid", valid, 1);
        chk("coin_ovr", ovr, 0);
        chk("coin_period", period, 15);
        chk("coin_width", width, 6);

        // randomized run against the model
        reset_dut();
        model_reset();
        model_on = 1;
        psc = 5'($urandom_range(0, 3));
        en = 1;
        run = 0;
        off = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run == 0) begin
                cap_in = ~cap_in;
                run = $urandom_range(1, 20);
            end
            run--;
            ack = ($urandom_range(0, 7) == 0);
            if (off > 0) begin
                off--;
                en = (off == 0);
            end else if ($urandom_range(0, 199) == 0) begin
                off = $urandom_range(1, 6);
                en = 0;
            end
            cyc();
        end
        model_on = 0;
        ack = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
